mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin front end for `mem_model`: accepts word read/write requests from `N_CLIENTS` requesters over valid/ready handshakes, issues at most one memory operation per cycle on the `mem_model` read/write ports, and returns read data to the issuing client through an in-order response FIFO. It sits between the core load/store paths and the behavioral memory. It throttles reads with credits, so the 1-cycle `read_valid` pulse from memory is never dropped.

## Interface
- `N_CLIENTS`, `config_pkg::MEM_ARB_CLIENTS` (2): number of requesters, 1..8.
- `RSP_DEPTH`, `config_pkg::MEM_RSP_DEPTH` (4): response FIFO entries, power of two, at least 2.
- `DEBUG`, `config_pkg::DEBUG`: enables `$display` of grants and responses.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in [N_CLIENTS]: client request valid.
- `req_ready` out [N_CLIENTS]: request accepted this cycle.
- `req_we` in [N_CLIENTS]: 1 = write (posted, no response), 0 = read.
- `req_addr` in [N_CLIENTS][32]: word index.
- `req_wdata` in [N_CLIENTS][32]: write data.
- `rsp_valid` out [N_CLIENTS]: read data valid for this client.
- `rsp_ready` in [N_CLIENTS]: client accepts response.
- `rsp_data` out 32: read data, shared across clients and qualified by `rsp_valid[i]`.
- `mem_read_en` out 1, `mem_read_addr` out 32: to `mem_model` read port.
- `mem_read_data` in 32, `mem_read_valid` in 1: from `mem_model`, 1 cycle after `mem_read_en`.
- `mem_write_en` out 1, `mem_write_addr` out 32, `mem_write_data` out 32: to `mem_model` write port.

## Operation
- **Eligibility:** client i is eligible when `req_valid[i]` is high and either `req_we[i]` is 1, or a read credit exists: `fifo_count + inflight < RSP_DEPTH`.
- **Grant:** exactly one grant per cycle, to the first eligible client at or after `rr_ptr`, wrapping. `req_ready` is one-hot or zero and is combinational from `req_valid`/`req_we`. Clients must not make valid depend on ready.
- **Round-robin pointer:** on a grant to client g, `rr_ptr <= (g+1) mod N_CLIENTS`. With no grant, `rr_ptr` holds.
- **Granted write:** `mem_write_en`/`_addr`/`_data` are driven combinationally in the grant cycle. No response is generated.
- **Granted read:** `mem_read_en`/`_addr` are driven combinationally. Registers update to `inflight <= 1` and `inflight_id <= g`. With no read grant, `inflight <= 0`.
- **Read return:** when `mem_read_valid` is high and `inflight` was set, push {`inflight_id`, `mem_read_data`} into the FIFO. A `mem_read_valid` with no matching inflight is ignored; in DEBUG builds it triggers a `$display` warning.
- **Response output:** the FIFO head drives `rsp_data`, and `rsp_valid[head_id]` is high when the FIFO is non-empty. A pop occurs on `rsp_ready[head_id]`. Responses are strictly in issue order; head-of-line blocking across clients is intended.
- **Simultaneous push and pop:** count is unchanged. Push into a full FIFO cannot occur by construction; assert this in simulation.
- **Out-of-range addresses:** passed through unmodified. `mem_model` returns 0.

## Timing
- Read request accepted in cycle T, so `mem_read_en` is high in T. `mem_read_valid` arrives in T+1 and is pushed at the end of T+1, giving `rsp_valid` earliest in T+2. Minimum read latency is 2 cycles.
- A write accepted in T updates memory at the end of T. A read accepted in T+1 to the same address returns the new data.
- **Sustained throughput:** 1 request per cycle while credits exist. With the FIFO holding `RSP_DEPTH-1` entries plus one inflight, reads stall while writes continue.
- **Reset values:** `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `mem_*_en` 0, `mem_*_addr`/`data` 0, `rr_ptr` 0, `inflight` 0, FIFO empty.
- **Reset mid-operation:** inflight reads and queued responses are discarded. `mem_model` clears its `read_valid` on the same reset.

## Structure
- `config_pkg` gains `MEM_ARB_CLIENTS`, `MEM_RSP_DEPTH`, and typedef `mem_rsp_t` = {client id `[$clog2(MEM_ARB_CLIENTS)-1:0]`, data `[31:0]`}.
- Sub-module `mem_rsp_fifo`: synchronous FIFO of `mem_rsp_t` with depth parameter, push/pop, `count`, `empty`/`full`, async active-low reset.
- Arbitration, credit logic and the inflight register live in `mem_arbiter`.

## Test plan
- **Single read:** preload `mem[5]=0xDEADBEEF`; client 0 reads addr 5 in cycle T. Expect `mem_read_en` high in T, `rsp_valid[0]` high in T+2 with `rsp_data=0xDEADBEEF`.
- **Write then read:** client 1 writes `0x12345678` to addr 9, then reads addr 9 the next cycle. Expect response `0x12345678`, with no response for the write.
- **Fairness:** both clients hold continuous reads with `rsp_ready` tied high. Expect grants alternating 0,1,0,1 and responses routed to matching `rsp_valid` bits in order.
- **Credit stall:** `rsp_ready`=0, client 0 streams reads of addrs 0..9. Expect exactly 4 accepted and `req_ready[0]` low afterwards. A client 1 write is still accepted. Releasing `rsp_ready` drains 4 responses in order, then reads resume.
- **Head-of-line:** FIFO head belongs to client 0 with `rsp_ready[0]`=0 and `rsp_ready[1]`=1. Expect no client 1 response until client 0 pops.
- **Reset:** assert `rst_n` low one cycle after a read grant. Expect all outputs at reset values and no response after reset release.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration for the memory front end: client count, response depth
// and the response FIFO entry type.
package config_pkg;

    localparam bit DEBUG           = 1'b0;
    localparam int MEM_ARB_CLIENTS = 2;
    localparam int MEM_RSP_DEPTH   = 4;
    localparam int MEM_ARB_ID_W    = (MEM_ARB_CLIENTS > 1) ? $clog2(MEM_ARB_CLIENTS) : 1;

    typedef struct packed {
        logic [MEM_ARB_ID_W-1:0] id;
        logic [31:0]             data;
    } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order response FIFO for mem_arbiter; DEPTH must be a power of two so the
// pointers wrap naturally.
module mem_rsp_fifo
    import config_pkg::*;
#(
    parameter type T     = mem_rsp_t,
    parameter int  DEPTH = MEM_RSP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end for mem_model: one memory op per cycle, reads throttled
// by credits so every read_valid pulse has a guaranteed FIFO slot.
module mem_arbiter
    import config_pkg::*;
#(
    parameter int N_CLIENTS = MEM_ARB_CLIENTS,
    parameter int RSP_DEPTH = MEM_RSP_DEPTH,
    parameter bit DEBUG     = config_pkg::DEBUG
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CLIENTS-1:0]       req_valid,
    output logic [N_CLIENTS-1:0]       req_ready,
    input  logic [N_CLIENTS-1:0]       req_we,
    input  logic [N_CLIENTS-1:0][31:0] req_addr,
    input  logic [N_CLIENTS-1:0][31:0] req_wdata,
    output logic [N_CLIENTS-1:0]       rsp_valid,
    input  logic [N_CLIENTS-1:0]       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic                       mem_read_en,
    output logic [31:0]                mem_read_addr,
    input  logic [31:0]                mem_read_data,
    input  logic                       mem_read_valid,
    output logic                       mem_write_en,
    output logic [31:0]                mem_write_addr,
    output logic [31:0]                mem_write_data
);

    localparam int ID_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int CW   = $clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } rsp_t;

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 inflight_q, inflight_d;
    logic [ID_W-1:0]      inflight_id_q, inflight_id_d;
    logic [N_CLIENTS-1:0] elig;
    logic                 credit_ok;
    logic                 gnt_vld;
    logic [ID_W-1:0]      gnt_id;
    logic [ID_W-1:0]      idx;
    int                   sel;
    logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]        fifo_count;
    rsp_t                 fifo_din, fifo_head;

    always_comb begin
        // Queued plus inflight reads must fit in the FIFO before another read issues.
        credit_ok = (int'(fifo_count) + int'(inflight_q)) < RSP_DEPTH;
        elig      = req_valid & (req_we | {N_CLIENTS{credit_ok}}) & {N_CLIENTS{rst_n}};
        gnt_vld   = 1'b0;
        gnt_id    = '0;
        sel       = 0;
        idx       = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            sel = int'(rr_ptr_q) + k;
            if (sel >= N_CLIENTS) sel = sel - N_CLIENTS;
            idx = ID_W'(sel);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end

        req_ready      = '0;
        mem_read_en    = 1'b0;
        mem_read_addr  = '0;
        mem_write_en   = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
            if (req_we[gnt_id]) begin
                mem_write_en   = 1'b1;
                mem_write_addr = req_addr[gnt_id];
                mem_write_data = req_wdata[gnt_id];
            end else begin
                mem_read_en   = 1'b1;
                mem_read_addr = req_addr[gnt_id];
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) rr_ptr_d = (gnt_id == ID_W'(N_CLIENTS-1)) ? '0 : gnt_id + 1'b1;
        inflight_d    = mem_read_en;
        inflight_id_d = mem_read_en ? gnt_id : inflight_id_q;

        fifo_push = mem_read_valid && inflight_q;
        fifo_din  = '{id: inflight_id_q, data: mem_read_data};

        rsp_valid = '0;
        rsp_data  = '0;
        fifo_pop  = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[fifo_head.id] = 1'b1;
            rsp_data                = fifo_head.data;
            fifo_pop                = rsp_ready[fifo_head.id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
        end
    end

    mem_rsp_fifo #(.T(rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full));

    a_stray_read_valid: assert property (@(posedge clk) disable iff (!rst_n || !DEBUG)
        mem_read_valid |-> inflight_q)
        else $warning("mem_arbiter: read_valid with no inflight read ignored");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency memory model attached.
module tb_mem_arbiter;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [N-1:0][31:0] req_addr, req_wdata;
    logic [31:0]      rsp_data, mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic             mem_read_en, mem_read_valid, mem_write_en;
    logic [31:0]      mem [0:63];
    int               n_chk = 0;
    int               n_fail = 0;
    int               a;

    always #5 clk = ~clk;

    mem_arbiter #(.N_CLIENTS(N), .RSP_DEPTH(4), .DEBUG(1'b0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_read_valid (mem_read_valid),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    // Memory stand-in: read data one cycle after read_en, out-of-range reads return 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_valid <= 1'b0;
            mem_read_data  <= '0;
        end else begin
            mem_read_valid <= mem_read_en;
            mem_read_data  <= (mem_read_addr < 64) ? mem[mem_read_addr[5:0]] : 32'h0;
        end
    end

    always @(posedge clk) begin
        if (mem_write_en && mem_write_addr < 64) mem[mem_write_addr[5:0]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv(input logic c, input logic v, input logic we,
                       input logic [31:0] ad, input logic [31:0] d);
        req_valid[c] = v;
        req_we[c]    = we;
        req_addr[c]  = ad;
        req_wdata[c] = d;
    endtask

    // Memory contents after preload and the two directed writes.
    function automatic logic [31:0] val(input int ad);
        if (ad == 5) return 32'hDEADBEEF;
        if (ad == 9) return 32'h12345678;
        return 32'h100 + ad;
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
        drv(1'b0, 1'b1, 1'b0, 32'd7, 32'd0);
        drv(1'b1, 1'b1, 1'b0, 32'd8, 32'd0);
        smp();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rd_en", 32'(mem_read_en), 32'd0);
        chk("rst_wr_en", 32'(mem_write_en), 32'd0);
        chk("rst_rd_addr", mem_read_addr, 32'd0);
        chk("rst_wr_addr", mem_write_addr, 32'd0);
        chk("rst_wr_data", mem_write_data, 32'd0);
        tick();
        rst_n = 1'b1; req_valid = '0;

        // preload mem[i] = 0x100+i
        for (int i = 0; i < 10; i++) begin
            drv(1'b0, 1'b1, 1'b1, 32'(i), 32'h100 + 32'(i));
            smp();
            chk("pre_ready", 32'(req_ready), 32'd1);
            tick();
        end

        // single read
        drv(1'b0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
        smp(); chk("t1_wr_en", 32'(mem_write_en), 32'd1); chk("t1_wr_data", mem_write_data, 32'hDEADBEEF);
        tick();
        drv(1'b0, 1'b1, 1'b0, 32'd5, 32'd0); rsp_ready = '1;
        smp(); chk("t1_rd_en", 32'(mem_read_en), 32'd1); chk("t1_rd_addr", mem_read_addr, 32'd5);
        chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = '0;
        smp(); chk("t1_rsp_t1", 32'(rsp_valid), 32'd0);
        tick();
        smp(); chk("t1_rsp_valid", 32'(rsp_valid), 32'd1); chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
        tick();

        // write then read on client 1
        drv(1'b1, 1'b1, 1'b1, 32'd9, 32'h12345678);
        smp(); chk("t2_wr_ready", 32'(req_ready), 32'd2); chk("t2_wr_addr", mem_write_addr, 32'd9);
        tick();
        drv(1'b1, 1'b1, 1'b0, 32'd9, 32'd0);
        smp(); chk("t2_rd_en", 32'(mem_read_en), 32'd1); chk("t2_no_wr_rsp", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = '0;
        smp(); chk("t2_rsp_t1", 32'(rsp_valid), 32'd0);
        tick();
        smp(); chk("t2_rsp_valid", 32'(rsp_valid), 32'd2); chk("t2_rsp_data", rsp_data, 32'h12345678);
        tick();

        // fairness: both clients read continuously
        drv(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        drv(1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) req_valid = '0;
            smp();
            if (c < 6) chk("fair_gnt", 32'(req_ready), (c % 2 != 0) ? 32'd2 : 32'd1);
            if (c >= 2) begin
                chk("fair_rsp_vld", 32'(rsp_valid), ((c - 2) % 2 != 0) ? 32'd2 : 32'd1);
                chk("fair_rsp_data", rsp_data, ((c - 2) % 2 != 0) ? val(1) : val(0));
            end
            tick();
        end
        repeat (2) tick();

        // credit stall with responses held
        rsp_ready = '0; a = 0;
        drv(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int c = 0; c < 8; c++) begin
            smp();
            if (req_ready[0]) a++;
            tick();
            req_addr[0] = 32'(a);
        end
        chk("stall_accepts", 32'(a), 32'd4);
        drv(1'b1, 1'b1, 1'b1, 32'd30, 32'hCAFE0030);
        smp(); chk("stall_wr_ready", 32'(req_ready), 32'd2); chk("stall_wr_en", 32'(mem_write_en), 32'd1);
        tick();
        req_valid[1] = 1'b0; rsp_ready = 2'b01;
        for (int j = 0; j < 8; j++) begin
            if (a >= 10) req_valid[0] = 1'b0;
            smp();
            if (j == 0) chk("drain_still_stalled", 32'(req_ready), 32'd0);
            if (j == 1) chk("drain_resume", 32'(req_ready), 32'd1);
            chk("drain_vld", 32'(rsp_valid), 32'd1);
            chk("drain_data", rsp_data, val(j));
            if (req_ready[0]) a++;
            tick();
            req_addr[0] = 32'(a);
        end
        req_valid = '0; rsp_ready = '1;
        repeat (4) tick();
        smp(); chk("flush_empty", 32'(rsp_valid), 32'd0);
        tick();

        // head-of-line blocking
        rsp_ready = 2'b10;
        drv(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        smp(); tick();
        req_valid[0] = 1'b0;
        drv(1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
        smp(); tick();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            smp();
            chk("hol_block", 32'(rsp_valid), 32'd1);
            tick();
        end
        rsp_ready = '1;
        smp(); chk("hol_c0_vld", 32'(rsp_valid), 32'd1); chk("hol_c0_data", rsp_data, val(0));
        tick();
        smp(); chk("hol_c1_vld", 32'(rsp_valid), 32'd2); chk("hol_c1_data", rsp_data, val(1));
        tick();

        // reset one cycle after a read grant
        drv(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        smp(); chk("rst2_gnt", 32'(mem_read_en), 32'd1);
        tick();
        rst_n = 1'b0;
        smp();
        chk("rst2_req_ready", 32'(req_ready), 32'd0);
        chk("rst2_rd_en", 32'(mem_read_en), 32'd0);
        chk("rst2_rd_addr", mem_read_addr, 32'd0);
        chk("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst2_rsp_data", rsp_data, 32'd0);
        tick();
        rst_n = 1'b1; req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk("rst2_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
